cavlc_field_demux: RTL and testbench
====================================

Name: cavlc_field_demux

Overview:
- Receive-side counterpart of the CAVLC output bit mux.
- Consumes the serial CAVLC bitstream MSB-first and, under field requests from the decoder controller, packs bits into tagged parallel fields: coeff_token, trailing_ones_sign, levels, total_zeros, run_before.
- Supports fixed-length fields and unary, zero-run-terminated fields (level_prefix style).
- Sits between the bitstream source and the CAVLC decode controller and table lookups.

Parameters:
- DATA_W, 16, width of fld_data; maximum fixed field length.
- MAX_UNARY, 15, maximum leading zeros accepted in unary mode before error.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-low reset.
- bit_in  in  1  serial bitstream bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  block consumes bit_in this cycle when bit_valid is also 1.
- req_valid  in  1  field request valid.
- req_ready  out  1  request accepted when req_valid is also 1.
- req_sel  in  3  field tag: 000 coeff_token, 001 trailing_ones_sign, 010 levels, 011 total_zeros, 100 run_before; 101-111 reserved.
- req_len  in  5  fixed field length 1..DATA_W; 0 selects unary mode.
- fld_valid  out  1  output field valid.
- fld_ready  in  1  downstream accepts the field.
- fld_sel  out  3  tag of the completed field.
- fld_data  out  DATA_W  field value, right-aligned; in unary mode, the zero count.
- fld_len  out  5  bits consumed for this field; unary mode includes the terminating 1.
- err  out  1  one-cycle error pulse.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-low on RST.
- Reset values: all outputs 0; state IDLE; internal shift register and counters 0.
- Reset mid-field discards the partial field. No fld_valid is issued for it.
- Handshakes: valid/ready on all three interfaces. A transfer occurs only on valid&ready at a rising edge of CLK. Outputs are registered.
- req_ready is 1 only in IDLE. bit_ready is 1 only in SHIFT or UNARY.
- fld_valid, fld_sel, fld_data and fld_len are held stable until fld_ready.

State machine:
- IDLE:
  - On req accept, latch sel and len.
  - len==0 goes to UNARY.
  - len in 1..DATA_W goes to SHIFT.
  - len>DATA_W or req_sel>100: pulse err, stay in IDLE, consume no bits.
- SHIFT:
  - Each accepted bit: data <= {data[DATA_W-2:0], bit_in}; cnt <= cnt+1.
  - The accept of bit number len goes to OUT in the same edge.
  - Upper bits of data above len are 0.
- UNARY:
  - Accepted 0: zcnt <= zcnt+1.
  - Accepted 1: go to OUT with fld_data = zcnt and fld_len = zcnt+1.
  - Accepted 0 while zcnt==MAX_UNARY: pulse err, return to IDLE, discard the field.
- OUT:
  - fld_valid=1.
  - On fld_ready go to IDLE. req_ready returns the following cycle.
- Gaps: bit_valid=0 in SHIFT or UNARY stalls without state change.
- Throughput: one bit per cycle.
- Latency: fld_valid rises the cycle after the last bit is accepted.
- Per-field overhead: 2 cycles (IDLE accept plus OUT), with fld_ready held high.
- No bits are consumed in IDLE or OUT. Bits presented there stay pending upstream.
- Counters are 5-bit. cnt and zcnt clear on entry to SHIFT or UNARY.

Optional Feature:
- Macro: CAVLC_BITCNT_EN.
- Defined:
  - Adds output bit_cnt, out, 16 bits: running count of consumed bits.
  - Increments on every bit accept and wraps at 65535 to 0.
  - Adds input cnt_clr, in, 1: synchronous clear. cnt_clr has priority over a simultaneous increment.
  - Reset value of bit_cnt is 0.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package cavlc_pkg:
  - field tag constants FLD_COEFF_TOKEN=3'b000, FLD_T1_SIGN=3'b001, FLD_LEVELS=3'b010, FLD_TOTAL_ZEROS=3'b011, FLD_RUN_BEFORE=3'b100;
  - state encoding IDLE/SHIFT/UNARY/OUT;
  - REQ_LEN_UNARY=5'd0.
- The tags are shared with the encoder-side mux select.
- No sub-module; single FSM plus datapath.

Test Plan:
- Fixed field:
  - Stimulus: req sel=000 len=6; bits 0,0,0,1,0,1.
  - Response: fld_sel=000, fld_data=16'h0005, fld_len=6; fld_valid 1 cycle after the 6th bit.
- Unary field:
  - Stimulus: req len=0; bits 0,0,0,1.
  - Response: fld_data=3, fld_len=4, sel echoed.
- Backpressure and gaps:
  - Stimulus: len=3 with bit_valid gaps of 2 cycles; fld_ready low 5 cycles.
  - Response: data stable and correct; bit_ready=0 and req_ready=0 while fld_valid waits.
- Errors:
  - Stimulus: req len=17.
  - Response: err pulse, no bits consumed.
  - Stimulus: unary with 16 consecutive zeros.
  - Response: err on the 16th zero, return to IDLE, no fld_valid.
- Reset mid-field:
  - Stimulus: RST low after 3 of 8 bits.
  - Response: next cycle all outputs 0; a new req len=2 with bits 1,1 gives fld_data=3.
- CAVLC_BITCNT_EN:
  - Stimulus: the fields above consuming 6+4 bits.
  - Response: bit_cnt=10; cnt_clr together with a bit accept gives bit_cnt=0.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared CAVLC field tags (common with the encoder-side mux select), demux FSM
// state encoding and the request-length code that selects unary mode.
package cavlc_pkg;

  localparam logic [2:0] FLD_COEFF_TOKEN = 3'b000;
  localparam logic [2:0] FLD_T1_SIGN     = 3'b001;
  localparam logic [2:0] FLD_LEVELS      = 3'b010;
  localparam logic [2:0] FLD_TOTAL_ZEROS = 3'b011;
  localparam logic [2:0] FLD_RUN_BEFORE  = 3'b100;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] UNARY = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [4:0] REQ_LEN_UNARY = 5'd0;

endpackage

// File: rtl/cavlc_field_demux_if.sv
// Bit, request and field handshakes of the CAVLC field demux.
// CAVLC_BITCNT_EN adds the running bit counter and its clear.
interface cavlc_field_demux_if #(
  parameter int unsigned DATA_W = 16
);
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_sel;
  logic [4:0]        req_len;
  logic              fld_valid;
  logic              fld_ready;
  logic [2:0]        fld_sel;
  logic [DATA_W-1:0] fld_data;
  logic [4:0]        fld_len;
  logic              err;
`ifdef CAVLC_BITCNT_EN
  logic [15:0]       bit_cnt;
  logic              cnt_clr;
`endif

  modport master (
`ifdef CAVLC_BITCNT_EN
    input  bit_cnt,
    output cnt_clr,
`endif
    output bit_in, bit_valid, req_valid, req_sel, req_len, fld_ready,
    input  bit_ready, req_ready, fld_valid, fld_sel, fld_data, fld_len, err
  );

  modport slave (
`ifdef CAVLC_BITCNT_EN
    output bit_cnt,
    input  cnt_clr,
`endif
    input  bit_in, bit_valid, req_valid, req_sel, req_len, fld_ready,
    output bit_ready, req_ready, fld_valid, fld_sel, fld_data, fld_len, err
  );

endinterface

// File: rtl/cavlc_field_demux.sv
// Packs the serial CAVLC bitstream (MSB-first) into tagged fixed-length or unary fields.
// Optional running bit counter enabled with CAVLC_BITCNT_EN.
module cavlc_field_demux #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_UNARY = 15
) (
  input  logic                CLK,
  input  logic                RST,
  cavlc_field_demux_if.slave  bus
);
  import cavlc_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [4:0]        len_q, len_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        zcnt_q, zcnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        flen_q, flen_d;
  logic              err_q, err_d;
  logic              bit_acc, req_acc, req_bad;

  // req_ready is masked by RST so every output reads 0 while reset is held.
  assign bus.req_ready = (state_q == IDLE) & RST;
  assign bus.bit_ready = (state_q == SHIFT) | (state_q == UNARY);
  assign bus.fld_valid = (state_q == OUT);
  assign bus.fld_sel   = sel_q;
  assign bus.fld_data  = data_q;
  assign bus.fld_len   = flen_q;
  assign bus.err       = err_q;

  assign bit_acc = bus.bit_valid & bus.bit_ready;
  assign req_acc = bus.req_valid & bus.req_ready;
  assign req_bad = (32'(bus.req_len) > DATA_W) | (bus.req_sel > FLD_RUN_BEFORE);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    zcnt_d  = zcnt_q;
    data_d  = data_q;
    flen_d  = flen_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_acc) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            sel_d   = bus.req_sel;
            len_d   = bus.req_len;
            cnt_d   = '0;
            zcnt_d  = '0;
            data_d  = '0;
            flen_d  = '0;
            state_d = (bus.req_len == REQ_LEN_UNARY) ? UNARY : SHIFT;
          end
        end
      end
      SHIFT: begin
        if (bit_acc) begin
          data_d = {data_q[DATA_W-2:0], bus.bit_in};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == len_q) begin
            flen_d  = len_q;
            state_d = OUT;
          end
        end
      end
      UNARY: begin
        if (bit_acc) begin
          if (bus.bit_in) begin
            data_d  = DATA_W'(zcnt_q);
            flen_d  = zcnt_q + 5'd1;
            state_d = OUT;
          end else if (zcnt_q == 5'(MAX_UNARY)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            zcnt_d = zcnt_q + 5'd1;
          end
        end
      end
      OUT: begin
        if (bus.fld_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      zcnt_q  <= '0;
      data_q  <= '0;
      flen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      zcnt_q  <= zcnt_d;
      data_q  <= data_d;
      flen_q  <= flen_d;
      err_q   <= err_d;
    end
  end

`ifdef CAVLC_BITCNT_EN
  logic [15:0] bitcnt_q, bitcnt_d;

  // Clear wins over a same-cycle accept; the counter wraps naturally.
  always_comb begin
    bitcnt_d = bitcnt_q;
    if (bus.cnt_clr) begin
      bitcnt_d = '0;
    end else if (bit_acc) begin
      bitcnt_d = bitcnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      bitcnt_q <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
    end
  end

  assign bus.bit_cnt = bitcnt_q;
`endif

endmodule

// File: tb/tb_cavlc_field_demux.sv
// Directed, table-driven bench for cavlc_field_demux (fixed, unary, backpressure,
// error and reset cases; bit counter when CAVLC_BITCNT_EN is defined).
module tb_cavlc_field_demux;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
`ifdef CAVLC_BITCNT_EN
  int   exp_bc;
`endif

  cavlc_field_demux_if #(.DATA_W(16)) bus();

  cavlc_field_demux #(.DATA_W(16), .MAX_UNARY(15)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = normal field, 1 = rejected request, 2 = unary overflow
  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  len;
    logic [15:0] bits;
    int          nbits;
    int          gap;
    int          rdy;
    int          kind;
    logic [15:0] exp_data;
    logic [4:0]  exp_len;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bus.fld_ready = (v.rdy == 0);
    bus.req_sel   = v.sel;
    bus.req_len   = v.len;
    bus.req_valid = 1'b1;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    if (v.kind == 1) begin
      chk("req_err_pulse", 32'(bus.err), 32'd1);
      chk("req_err_no_bits", 32'(bus.bit_ready), 32'd0);
      chk("req_err_idle", 32'(bus.req_ready), 32'd1);
      step();
      chk("req_err_one_cycle", 32'(bus.err), 32'd0);
      return;
    end
    for (int i = 0; i < v.nbits; i++) begin
      bus.bit_in    = v.bits[v.nbits-1-i];
      bus.bit_valid = 1'b1;
      chk("bit_ready", 32'(bus.bit_ready), 32'd1);
      step();
`ifdef CAVLC_BITCNT_EN
      exp_bc++;
`endif
      bus.bit_valid = 1'b0;
      if (i < v.nbits - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          chk("gap_stall", 32'(bus.bit_ready), 32'd1);
          step();
        end
      end
    end
    if (v.kind == 2) begin
      chk("unary_ovf_err", 32'(bus.err), 32'd1);
      chk("unary_ovf_noval", 32'(bus.fld_valid), 32'd0);
      chk("unary_ovf_idle", 32'(bus.req_ready), 32'd1);
      step();
      chk("unary_ovf_one_cycle", 32'(bus.err), 32'd0);
      chk("unary_ovf_noval2", 32'(bus.fld_valid), 32'd0);
      return;
    end
    chk("fld_valid", 32'(bus.fld_valid), 32'd1);
    chk("fld_sel", 32'(bus.fld_sel), 32'(v.sel));
    chk("fld_data", 32'(bus.fld_data), 32'(v.exp_data));
    chk("fld_len", 32'(bus.fld_len), 32'(v.exp_len));
    for (int k = 0; k < v.rdy; k++) begin
      bus.bit_in    = 1'b1;
      bus.bit_valid = 1'b1;
      chk("bp_valid", 32'(bus.fld_valid), 32'd1);
      chk("bp_data", 32'(bus.fld_data), 32'(v.exp_data));
      chk("bp_bit_ready", 32'(bus.bit_ready), 32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.bit_valid = 1'b0;
    bus.fld_ready = 1'b1;
    step();
    chk("fld_done", 32'(bus.fld_valid), 32'd0);
    chk("req_ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    bus.req_len   = '0;
    bus.fld_ready = 1'b1;
`ifdef CAVLC_BITCNT_EN
    bus.cnt_clr   = 1'b0;
    exp_bc        = 0;
`endif

    //          sel     len    bits        n  gap rdy kind data      len
    vecs[0] = '{3'b000, 5'd6,  16'h0005,   6, 0,  0,  0,  16'h0005, 5'd6};
    vecs[1] = '{3'b010, 5'd0,  16'h0001,   4, 0,  0,  0,  16'h0003, 5'd4};
    vecs[2] = '{3'b011, 5'd3,  16'h0005,   3, 2,  5,  0,  16'h0005, 5'd3};
    vecs[3] = '{3'b001, 5'd17, 16'h0000,   0, 0,  0,  1,  16'h0000, 5'd0};
    vecs[4] = '{3'b101, 5'd4,  16'h0000,   0, 0,  0,  1,  16'h0000, 5'd0};
    vecs[5] = '{3'b010, 5'd0,  16'h0000,  16, 0,  0,  2,  16'h0000, 5'd0};
    vecs[6] = '{3'b100, 5'd16, 16'hA5C3,  16, 0,  0,  0,  16'hA5C3, 5'd16};
    vecs[7] = '{3'b001, 5'd0,  16'h0001,   1, 0,  0,  0,  16'h0000, 5'd1};
    vecs[8] = '{3'b010, 5'd0,  16'h0001,  16, 1,  0,  0,  16'h000F, 5'd16};
    vecs[9] = '{3'b001, 5'd1,  16'h0001,   1, 0,  2,  0,  16'h0001, 5'd1};

    step();
    step();
    chk("rst_fld_valid", 32'(bus.fld_valid), 32'd0);
    chk("rst_fld_data", 32'(bus.fld_data), 32'd0);
    chk("rst_fld_len", 32'(bus.fld_len), 32'd0);
    chk("rst_fld_sel", 32'(bus.fld_sel), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
`ifdef CAVLC_BITCNT_EN
    chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 10; n++) begin
      run_vec(vecs[n]);
`ifdef CAVLC_BITCNT_EN
      if (n == 1) chk("bitcnt_6p4", 32'(bus.bit_cnt), 32'd10);
      chk("bitcnt_model", 32'(bus.bit_cnt), 32'(exp_bc));
`endif
    end

    // Reset three bits into an 8-bit field, then a fresh 2-bit field.
    bus.req_sel   = 3'b000;
    bus.req_len   = 5'd8;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.bit_in    = 1'b1;
      bus.bit_valid = 1'b1;
      step();
    end
    bus.bit_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_fld_valid", 32'(bus.fld_valid), 32'd0);
    chk("mid_rst_fld_data", 32'(bus.fld_data), 32'd0);
    chk("mid_rst_fld_len", 32'(bus.fld_len), 32'd0);
    chk("mid_rst_fld_sel", 32'(bus.fld_sel), 32'd0);
    chk("mid_rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
`ifdef CAVLC_BITCNT_EN
    chk("mid_rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    exp_bc = 0;
`endif
    rst_n = 1'b1;
    step();
    run_vec('{3'b011, 5'd2, 16'h0003, 2, 0, 0, 0, 16'h0003, 5'd2});

`ifdef CAVLC_BITCNT_EN
    chk("bitcnt_after_rst", 32'(bus.bit_cnt), 32'd2);
    bus.req_sel   = 3'b000;
    bus.req_len   = 5'd2;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    bus.cnt_clr   = 1'b1;
    step();
    bus.cnt_clr   = 1'b0;
    chk("bitcnt_clr_prio", 32'(bus.bit_cnt), 32'd0);
    bus.bit_in    = 1'b0;
    step();
    bus.bit_valid = 1'b0;
    chk("bitcnt_after_clr", 32'(bus.bit_cnt), 32'd1);
    chk("clr_fld_data", 32'(bus.fld_data), 32'h2);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
